// File: rtl/vend_pkg.sv
// ============================================================================
//  vend_pkg : shared constants, denomination table and FSM encoding for the
//             vending change path.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package vend_pkg;

  localparam int unsigned AMT_W   = 16;
  localparam int unsigned N_DENOM = 7;
  localparam int unsigned STOCK_W = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned DVAL_W  = 7;

  // Index 0 is the largest denomination; the picker relies on this ordering.
  localparam logic [DVAL_W-1:0] DENOM_VAL [0:N_DENOM-1] =
    '{7'd100, 7'd50, 7'd20, 7'd10, 7'd5, 7'd2, 7'd1};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_DONE     = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  function automatic logic [DVAL_W-1:0] denom_val(input logic [IDX_W-1:0] idx);
    logic [DVAL_W-1:0] v;
    v = '0;
    if (idx < IDX_W'(N_DENOM)) v = DENOM_VAL[idx];
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vend_denom_pick.sv
// ============================================================================
//  vend_denom_pick : combinational first-fit picker, returns the lowest index
//                    whose value fits the remainder and whose stock is non-zero.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module vend_denom_pick
  import vend_pkg::*;
#(
  parameter int AMTW   = AMT_W,
  parameter int NDENOM = N_DENOM,
  parameter int STOCKW = STOCK_W
) (
  input  logic [AMTW-1:0]               i_rem,
  input  logic [NDENOM-1:0][STOCKW-1:0] i_stock,
  output logic                          o_found,
  output logic [IDX_W-1:0]              o_idx
);

  // Scan from the smallest denomination upward so the largest fit wins last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = NDENOM - 1; i >= 0; i--) begin
      if ((i_stock[i] != '0) && (AMTW'(denom_val(IDX_W'(i))) <= i_rem)) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vend_change_sequencer.sv
// ============================================================================
//  vend_change_sequencer : greedy change payout sequencer with per-denomination
//                          stock tracking and dispenser ack timeout.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module vend_change_sequencer
  import vend_pkg::*;
#(
  parameter int AMTW   = AMT_W,
  parameter int NDENOM = N_DENOM,
  parameter int STOCKW = STOCK_W,
  parameter int TMO    = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              chg_valid,
  input  logic [AMTW-1:0]   chg_amount,
  output logic              chg_ready,
  input  logic              stock_wr,
  input  logic [2:0]        stock_sel,
  input  logic [STOCKW-1:0] stock_val,
  output logic              disp_req,
  output logic [2:0]        disp_denom,
  input  logic              disp_ack,
  output logic              done,
  output logic [AMTW-1:0]   short_amt,
  output logic              fault,
  input  logic              fault_clr
);

  localparam int TMOW = $clog2(TMO + 1);

  state_t                        r_state;
  state_t                        w_state_nx;
  logic [AMTW-1:0]               r_rem;
  logic [NDENOM-1:0][STOCKW-1:0] r_stock;
  logic [TMOW-1:0]               r_tmo_cnt;
  logic [IDX_W-1:0]              r_denom;
  logic [AMTW-1:0]               r_short;
  logic                          r_fault;

  logic                          w_found;
  logic [IDX_W-1:0]              w_idx;
  logic                          w_timeout;
  logic                          w_ack;
  logic                          w_wr_ok;

  vend_denom_pick #(
    .AMTW   (AMTW),
    .NDENOM (NDENOM),
    .STOCKW (STOCKW)
  ) u_pick (
    .i_rem   (r_rem),
    .i_stock (r_stock),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // The final timeout cycle drops disp_req, so an ack there is not a unit.
  assign w_timeout = (r_state == ST_DISPENSE) && (r_tmo_cnt == TMOW'(TMO));
  assign w_ack     = (r_state == ST_DISPENSE) && !w_timeout && disp_ack;
  assign w_wr_ok   = stock_wr && ({1'b0, stock_sel} < (IDX_W + 1)'(NDENOM));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    chg_ready  = 1'b0;
    disp_req   = 1'b0;
    done       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        chg_ready = 1'b1;
        if (chg_valid) w_state_nx = ST_SELECT;
      end
      ST_SELECT: begin
        w_state_nx = w_found ? ST_DISPENSE : ST_DONE;
      end
      ST_DISPENSE: begin
        disp_req = !w_timeout;
        if (w_timeout)     w_state_nx = ST_FAULT;
        else if (disp_ack) w_state_nx = ST_SELECT;
      end
      ST_DONE: begin
        done       = 1'b1;
        w_state_nx = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rem     <= '0;
      r_denom   <= '0;
      r_short   <= '0;
      r_tmo_cnt <= '0;
      r_fault   <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && chg_valid)
        r_rem <= chg_amount;
      else if (w_ack)
        r_rem <= r_rem - AMTW'(denom_val(r_denom));
      else if ((r_state == ST_FAULT) && fault_clr)
        r_rem <= '0;

      if ((r_state == ST_SELECT) && w_found) r_denom <= w_idx;
      // rem is zero or unpayable here, either way it is the shortfall.
      if ((r_state == ST_SELECT) && !w_found) r_short <= r_rem;

      if ((r_state != ST_DISPENSE) || w_ack || w_timeout)
        r_tmo_cnt <= '0;
      else
        r_tmo_cnt <= r_tmo_cnt + 1'b1;

      if (w_timeout)
        r_fault <= 1'b1;
      else if ((r_state == ST_FAULT) && fault_clr)
        r_fault <= 1'b0;
    end
  end

  // A host load on the same index as an ack decrement takes precedence.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stock <= '0;
    end else begin
      for (int i = 0; i < NDENOM; i++) begin
        if (w_wr_ok && (stock_sel == IDX_W'(i)))
          r_stock[i] <= stock_val;
        else if (w_ack && (r_denom == IDX_W'(i)) && (r_stock[i] != '0))
          r_stock[i] <= r_stock[i] - 1'b1;
      end
    end
  end

  assign disp_denom = r_denom;
  assign short_amt  = r_short;
  assign fault      = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_vend_change_sequencer.sv
// ============================================================================
//  tb_vend_change_sequencer : directed and randomized payouts checked against
//                             a greedy change model kept in the bench.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vend_change_sequencer;

  localparam int AMTW   = 16;
  localparam int NDENOM = 7;
  localparam int STOCKW = 8;
  localparam int TMO    = 255;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              chg_valid = 1'b0;
  logic [AMTW-1:0]   chg_amount = '0;
  logic              chg_ready;
  logic              stock_wr = 1'b0;
  logic [2:0]        stock_sel = '0;
  logic [STOCKW-1:0] stock_val = '0;
  logic              disp_req;
  logic [2:0]        disp_denom;
  logic              disp_ack = 1'b0;
  logic              done;
  logic [AMTW-1:0]   short_amt;
  logic              fault;
  logic              fault_clr = 1'b0;

  always #5 clk = ~clk;

  vend_change_sequencer #(
    .AMTW   (AMTW),
    .NDENOM (NDENOM),
    .STOCKW (STOCKW),
    .TMO    (TMO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .chg_valid  (chg_valid),
    .chg_amount (chg_amount),
    .chg_ready  (chg_ready),
    .stock_wr   (stock_wr),
    .stock_sel  (stock_sel),
    .stock_val  (stock_val),
    .disp_req   (disp_req),
    .disp_denom (disp_denom),
    .disp_ack   (disp_ack),
    .done       (done),
    .short_amt  (short_amt),
    .fault      (fault),
    .fault_clr  (fault_clr)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  int unsigned m_stock [NDENOM];
  int unsigned vals    [NDENOM] = '{100, 50, 20, 10, 5, 2, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_stock(input int sel, input int val);
    stock_wr  = 1'b1;
    stock_sel = 3'(sel);
    stock_val = STOCKW'(val);
    tick();
    stock_wr  = 1'b0;
    if (sel < NDENOM) m_stock[sel] = val;
  endtask

  task automatic load_all(input int val);
    for (int i = 0; i < NDENOM; i++) load_stock(i, val);
  endtask

  task automatic check_stock(input string tag);
    for (int i = 0; i < NDENOM; i++) check(tag, 32'(dut.r_stock[i]), m_stock[i]);
  endtask

  // Pays out one request, acking every unit after a random delay.
  task automatic run_txn(input int amt, input string tag);
    int exp_d[$];
    int rem;
    int pick;
    int guard;
    int dly;
    rem = amt;
    forever begin
      pick = -1;
      for (int i = 0; i < NDENOM; i++) begin
        if (vals[i] <= rem && m_stock[i] > 0) begin
          pick = i;
          break;
        end
      end
      if (pick < 0) break;
      exp_d.push_back(pick);
      rem -= vals[pick];
      m_stock[pick]--;
    end

    check({tag, "_ready"}, chg_ready, 1);
    chg_valid  = 1'b1;
    chg_amount = AMTW'(amt);
    tick();
    chg_valid  = 1'b0;
    chg_amount = AMTW'($urandom);
    check({tag, "_busy"}, chg_ready, 0);
    tick();

    if (exp_d.size() == 0) begin
      check({tag, "_done_lat"}, done, 1);
    end else begin
      foreach (exp_d[k]) begin
        if (k == 0) begin
          check({tag, "_req_lat"}, disp_req, 1);
        end else begin
          guard = 0;
          while (disp_req !== 1'b1 && guard < 8) begin
            tick();
            guard++;
          end
          check({tag, "_req"}, disp_req, 1);
        end
        check({tag, "_denom"}, disp_denom, exp_d[k]);
        dly = $urandom_range(0, 3);
        repeat (dly) begin
          chg_valid  = 1'($urandom);
          chg_amount = AMTW'($urandom);
          tick();
        end
        chg_valid = 1'b0;
        disp_ack  = 1'b1;
        tick();
        disp_ack  = 1'b0;
        check({tag, "_gap"}, disp_req, 0);
      end
      guard = 0;
      while (done !== 1'b1 && guard < 4) begin
        tick();
        guard++;
      end
      check({tag, "_done"}, done, 1);
    end
    check({tag, "_short"}, short_amt, rem);
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, chg_ready, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int cnt;
    int guard;
    for (int i = 0; i < NDENOM; i++) m_stock[i] = 0;

    repeat (3) tick();
    check("rst_ready", chg_ready, 1);
    check("rst_req", disp_req, 0);
    check("rst_denom", disp_denom, 0);
    check("rst_done", done, 0);
    check("rst_short", short_amt, 0);
    check("rst_fault", fault, 0);
    rstn = 1'b1;
    tick();
    check_stock("rst_stock");

    // T1..T4
    load_all(10);
    run_txn(150, "t1");
    check("t1_stock0", 32'(dut.r_stock[0]), 9);
    check("t1_stock1", 32'(dut.r_stock[1]), 9);
    load_all(10);
    run_txn(88, "t2");
    load_all(10);
    load_stock(0, 0);
    run_txn(150, "t3");
    load_all(10);
    load_stock(4, 0);
    load_stock(5, 0);
    load_stock(6, 0);
    run_txn(7, "t4");

    // Out-of-range select and a stray ack while idle must change nothing.
    load_stock(7, 5);
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    check_stock("sel7");
    run_txn(0, "zero");

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NDENOM; i++)
        if ($urandom_range(0, 2) == 0) load_stock(i, $urandom_range(0, 3));
      if (n == 5) load_stock(6, 255);
      run_txn($urandom_range(0, 400), "rnd");
    end
    check_stock("rnd_stock");

    // T5: dispenser never acks.
    load_stock(0, 1);
    chg_valid  = 1'b1;
    chg_amount = AMTW'(100);
    tick();
    chg_valid  = 1'b0;
    tick();
    cnt = 0;
    while (disp_req === 1'b1 && cnt < 300) begin
      cnt++;
      tick();
    end
    check("t5_req_cycles", cnt, 255);
    guard = 0;
    while (fault !== 1'b1 && guard < 3) begin
      tick();
      guard++;
    end
    check("t5_fault", fault, 1);
    check("t5_req_low", disp_req, 0);
    check("t5_not_ready", chg_ready, 0);
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    check("t5_no_done", done, 0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("t5_fault_clr", fault, 0);
    check("t5_ready", chg_ready, 1);
    check_stock("t5_stock");

    // T6a: host load collides with an ack decrement.
    load_all(0);
    load_stock(1, 3);
    chg_valid  = 1'b1;
    chg_amount = AMTW'(50);
    tick();
    chg_valid  = 1'b0;
    tick();
    check("t6_denom", disp_denom, 1);
    disp_ack  = 1'b1;
    stock_wr  = 1'b1;
    stock_sel = 3'd1;
    stock_val = STOCKW'(7);
    tick();
    disp_ack  = 1'b0;
    stock_wr  = 1'b0;
    m_stock[1] = 7;
    check("t6_collide", 32'(dut.r_stock[1]), 7);
    guard = 0;
    while (done !== 1'b1 && guard < 4) begin
      tick();
      guard++;
    end
    check("t6_done", done, 1);
    check("t6_short", short_amt, 0);
    tick();
    run_txn(7, "t6_short7");

    // T6b: reset lands in the middle of a dispense.
    load_stock(0, 2);
    chg_valid  = 1'b1;
    chg_amount = AMTW'(100);
    tick();
    chg_valid  = 1'b0;
    tick();
    check("t6_req_before", disp_req, 1);
    #1 rstn = 1'b0;
    #1;
    check("t6_rst_req", disp_req, 0);
    check("t6_rst_ready", chg_ready, 1);
    check("t6_rst_short", short_amt, 0);
    check("t6_rst_denom", disp_denom, 0);
    check("t6_rst_fault", fault, 0);
    check("t6_rst_done", done, 0);
    for (int i = 0; i < NDENOM; i++) m_stock[i] = 0;
    check_stock("t6_rst_stock");
    tick();
    rstn = 1'b1;
    tick();
    check("t6_post_ready", chg_ready, 1);
    load_stock(3, 2);
    run_txn(25, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
